// File: rtl/usb_txn_ctrl.sv
// USB host link-layer transaction sequencer: orders token/data/handshake phases,
// retries failed attempts up to MAX_RETRY and times out silent devices.
module usb_txn_ctrl #(
  parameter int MAX_RETRY = 8,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             read_write,
  input  logic             done_send_token,
  input  logic             done_send_data,
  input  logic             done_send_hand,
  input  logic             done_recv_data,
  input  logic             recv_data_ok,
  input  logic             done_recv_hand,
  input  logic [1:0]       hand_pid,
  output logic             start_send_token,
  output logic             start_send_data,
  output logic             start_send_hand,
  output logic             start_recv_data,
  output logic             start_recv_hand,
  output logic             busy,
  output logic             txn_done,
  output logic             txn_success,
  output logic             txn_stalled,
  output logic [CNT_W-1:0] fail_count,
  output logic [2:0]       state_dbg
);

  // Sub-block handshake: each start_* is a one-cycle pulse on the first cycle of
  // the phase's state; the sub-block answers with a one-cycle done_* pulse. A
  // done_* is only acted on while in the state that owns it, otherwise ignored.

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [1:0] PID_ACK   = 2'b00;
  localparam logic [1:0] PID_STALL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SEND_TOKEN = 3'd1,
    S_SEND_DATA  = 3'd2,
    S_WAIT_HAND  = 3'd3,
    S_WAIT_DATA  = 3'd4,
    S_SEND_HAND  = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             is_write;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             in_wait;
  logic             attempt_fail;
  logic             give_up;
  logic             set_success;
  logic             set_stall;
  logic             accept_start;
  logic [CNT_W-1:0] fail_inc;

  logic             entering;
  logic             send_token_nxt;
  logic             send_data_nxt;
  logic             send_hand_nxt;
  logic             recv_data_nxt;
  logic             recv_hand_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  assign state_dbg    = state;
  assign in_wait      = (state == S_WAIT_HAND) || (state == S_WAIT_DATA);
  assign tmo_hit      = in_wait && (tmo_cnt == TMO_LAST);
  assign accept_start = (state == S_IDLE) && start;

  // Failure counter saturates at all-ones; the give-up compare uses the
  // incremented value so the last permitted failure ends the transaction.
  assign fail_inc = (fail_count == {CNT_W{1'b1}}) ? fail_count : fail_count + 1'b1;
  assign give_up  = (int'(fail_inc) >= MAX_RETRY);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    attempt_fail = 1'b0;
    set_success  = 1'b0;
    set_stall    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_SEND_TOKEN;
      end
      S_SEND_TOKEN: begin
        if (done_send_token) state_nxt = is_write ? S_SEND_DATA : S_WAIT_DATA;
      end
      S_SEND_DATA: begin
        if (done_send_data) state_nxt = S_WAIT_HAND;
      end
      S_WAIT_HAND: begin
        // A response arriving on the last timeout cycle still counts.
        if (done_recv_hand) begin
          case (hand_pid)
            PID_ACK: begin
              state_nxt   = S_DONE;
              set_success = 1'b1;
            end
            PID_STALL: begin
              state_nxt = S_DONE;
              set_stall = 1'b1;
            end
            default: attempt_fail = 1'b1;
          endcase
        end else if (tmo_hit) begin
          attempt_fail = 1'b1;
        end
      end
      S_WAIT_DATA: begin
        if (done_recv_data) begin
          if (recv_data_ok) state_nxt = S_SEND_HAND;
          else              attempt_fail = 1'b1;
        end else if (tmo_hit) begin
          attempt_fail = 1'b1;
        end
      end
      S_SEND_HAND: begin
        if (done_send_hand) begin
          state_nxt   = S_DONE;
          set_success = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (attempt_fail) state_nxt = give_up ? S_DONE : S_SEND_TOKEN;
  end

  // Output decode: pulses are computed from the upcoming state and registered,
  // so every entry into a state (including a retry) re-launches its sub-block.
  always_comb begin
    entering       = (state_nxt != state);
    send_token_nxt = entering && (state_nxt == S_SEND_TOKEN);
    send_data_nxt  = entering && (state_nxt == S_SEND_DATA);
    send_hand_nxt  = entering && (state_nxt == S_SEND_HAND);
    recv_data_nxt  = entering && (state_nxt == S_WAIT_DATA);
    recv_hand_nxt  = entering && (state_nxt == S_WAIT_HAND);
    busy_nxt       = (state_nxt != S_IDLE);
    done_nxt       = (state_nxt == S_DONE);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      start_send_token <= 1'b0;
      start_send_data  <= 1'b0;
      start_send_hand  <= 1'b0;
      start_recv_data  <= 1'b0;
      start_recv_hand  <= 1'b0;
      busy             <= 1'b0;
      txn_done         <= 1'b0;
    end else begin
      start_send_token <= send_token_nxt;
      start_send_data  <= send_data_nxt;
      start_send_hand  <= send_hand_nxt;
      start_recv_data  <= recv_data_nxt;
      start_recv_hand  <= recv_hand_nxt;
      busy             <= busy_nxt;
      txn_done         <= done_nxt;
    end
  end

  // Transaction status: cleared when a start is accepted, set on the way to DONE,
  // and otherwise held so the controller can read it after txn_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_write    <= 1'b0;
      fail_count  <= '0;
      txn_success <= 1'b0;
      txn_stalled <= 1'b0;
    end else begin
      if (accept_start) begin
        is_write    <= read_write;
        fail_count  <= '0;
        txn_success <= 1'b0;
        txn_stalled <= 1'b0;
      end
      if (attempt_fail) fail_count  <= fail_inc;
      if (set_success)  txn_success <= 1'b1;
      if (set_stall)    txn_stalled <= 1'b1;
    end
  end

  // Response timer: zero on the first cycle of each wait, counts up to the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (entering && (state_nxt == S_WAIT_HAND || state_nxt == S_WAIT_DATA)) begin
      tmo_cnt <= '0;
    end else if (in_wait && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Randomized bench for usb_txn_ctrl: a device responder follows a per-attempt plan,
// a plan-level model predicts each transaction, and a monitor scores txn_done.
module tb_usb_txn_ctrl;

  localparam int MAX_RETRY = 8;
  localparam int TIMEOUT   = 10;
  localparam int CNT_W     = 4;
  localparam int W         = 64;
  localparam int TXN_BUDGET = 1000;

  // Per-attempt device behaviour
  localparam int K_GOOD   = 0;  // ACK / good data
  localparam int K_BAD    = 1;  // NAK / bad CRC
  localparam int K_STALL  = 2;
  localparam int K_INV    = 3;  // invalid PID
  localparam int K_SILENT = 4;  // no response at all
  localparam int K_LATE   = 5;  // good response on the last timeout cycle

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic read_write = 1'b0;
  logic done_send_token = 1'b0;
  logic done_send_data = 1'b0;
  logic done_send_hand = 1'b0;
  logic done_recv_data = 1'b0;
  logic recv_data_ok = 1'b0;
  logic done_recv_hand = 1'b0;
  logic [1:0] hand_pid = 2'b00;
  logic start_send_token, start_send_data, start_send_hand;
  logic start_recv_data, start_recv_hand;
  logic busy, txn_done, txn_success, txn_stalled;
  logic [CNT_W-1:0] fail_count;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  int plan[MAX_RETRY];
  logic plan_rw = 1'b0;
  int att = -1;

  always #5 clk = ~clk;

  usb_txn_ctrl #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .read_write(read_write),
    .done_send_token(done_send_token), .done_send_data(done_send_data),
    .done_send_hand(done_send_hand), .done_recv_data(done_recv_data),
    .recv_data_ok(recv_data_ok), .done_recv_hand(done_recv_hand), .hand_pid(hand_pid),
    .start_send_token(start_send_token), .start_send_data(start_send_data),
    .start_send_hand(start_send_hand), .start_recv_data(start_recv_data),
    .start_recv_hand(start_recv_hand), .busy(busy), .txn_done(txn_done),
    .txn_success(txn_success), .txn_stalled(txn_stalled), .fail_count(fail_count),
    .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: walk the attempt plan until the device succeeds, stalls,
  // or the retry budget is used up.
  // Layout: succ, stall, fails[4], tokens, send_data, recv_hand, recv_data, send_hand, timeouts.
  function automatic logic [W-1:0] model();
    int fails = 0, toks = 0, tmo = 0, shand = 0;
    logic succ = 1'b0, stl = 1'b0;
    for (int i = 0; i < MAX_RETRY; i++) begin
      toks++;
      if (plan[i] == K_SILENT) tmo++;
      if (plan[i] == K_GOOD || plan[i] == K_LATE) begin
        succ = 1'b1;
        if (!plan_rw) shand = 1;
        break;
      end
      if (plan_rw && plan[i] == K_STALL) begin
        stl = 1'b1;
        break;
      end
      fails++;
    end
    return {succ, stl, 4'(fails), 8'(toks), 8'(plan_rw ? toks : 0), 8'(plan_rw ? toks : 0),
            8'(plan_rw ? 0 : toks), 8'(shand), 8'(tmo), 10'd0};
  endfunction

  function automatic logic [1:0] pid_of(input int k);
    case (k)
      K_BAD:   return 2'b01;
      K_STALL: return 2'b10;
      K_INV:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // ---------------- clock/reset ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- device responder ----------------
  initial begin : responder
    int tok_cd, dat_cd, hnd_cd, rh_cd, rd_cd, idx;
    bit tok_a, dat_a, hnd_a, rh_a, rd_a;
    tok_a = 0; dat_a = 0; hnd_a = 0; rh_a = 0; rd_a = 0;
    tok_cd = 0; dat_cd = 0; hnd_cd = 0; rh_cd = 0; rd_cd = 0;
    forever begin
      @(negedge clk);
      done_send_token = 1'b0;
      done_send_data  = 1'b0;
      done_send_hand  = 1'b0;
      done_recv_data  = 1'b0;
      done_recv_hand  = 1'b0;
      hand_pid        = 2'($urandom_range(3, 0));
      recv_data_ok    = 1'($urandom_range(1, 0));
      if (!busy) begin
        tok_a = 0; dat_a = 0; hnd_a = 0; rh_a = 0; rd_a = 0;
      end else begin
        if (start_send_token) begin
          att++;
          tok_a = 1; tok_cd = $urandom_range(3, 1);
        end
        idx = (att < 0) ? 0 : ((att >= MAX_RETRY) ? MAX_RETRY - 1 : att);
        if (start_send_data) begin dat_a = 1; dat_cd = $urandom_range(3, 1); end
        if (start_send_hand) begin hnd_a = 1; hnd_cd = $urandom_range(3, 1); end
        if (start_recv_hand) begin
          rh_a  = (plan[idx] != K_SILENT);
          rh_cd = (plan[idx] == K_LATE) ? TIMEOUT - 1 : $urandom_range(6, 0);
        end
        if (start_recv_data) begin
          rd_a  = (plan[idx] != K_SILENT);
          rd_cd = (plan[idx] == K_LATE) ? TIMEOUT - 1 : $urandom_range(6, 0);
        end
        if (tok_a) begin if (tok_cd == 0) begin done_send_token = 1'b1; tok_a = 0; end else tok_cd--; end
        if (dat_a) begin if (dat_cd == 0) begin done_send_data = 1'b1; dat_a = 0; end else dat_cd--; end
        if (hnd_a) begin if (hnd_cd == 0) begin done_send_hand = 1'b1; hnd_a = 0; end else hnd_cd--; end
        if (rh_a) begin
          if (rh_cd == 0) begin
            done_recv_hand = 1'b1; hand_pid = pid_of(plan[idx]); rh_a = 0;
          end else rh_cd--;
        end
        if (rd_a) begin
          if (rd_cd == 0) begin
            done_recv_data = 1'b1; recv_data_ok = (plan[idx] != K_BAD); rd_a = 0;
          end else rd_cd--;
        end
        // Stray completions on channels this transaction type never uses.
        if (plan_rw) begin
          if ($urandom_range(7, 0) == 0) done_recv_data = 1'b1;
          if ($urandom_range(7, 0) == 0) done_send_hand = 1'b1;
        end else begin
          if ($urandom_range(7, 0) == 0) done_send_data = 1'b1;
          if ($urandom_range(7, 0) == 0) done_recv_hand = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int c_tok, c_sd, c_rh, c_rd, c_sh, c_tmo, wlen;
    bit in_wait, wdone, wait_hand, have_last;
    logic last_s, last_st;
    logic [CNT_W-1:0] last_fc;
    logic [W-1:0] e;
    c_tok = 0; c_sd = 0; c_rh = 0; c_rd = 0; c_sh = 0; c_tmo = 0; wlen = 0;
    in_wait = 0; wdone = 0; wait_hand = 0; have_last = 0;
    last_s = 1'b0; last_st = 1'b0; last_fc = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        c_tok = 0; c_sd = 0; c_rh = 0; c_rd = 0; c_sh = 0; c_tmo = 0;
        in_wait = 0; have_last = 1; last_s = 1'b0; last_st = 1'b0; last_fc = '0;
      end else begin
        if (in_wait) begin
          if ((wait_hand && done_recv_hand) || (!wait_hand && done_recv_data)) wdone = 1;
          if (start_send_token || start_send_hand || txn_done) begin
            if (!wdone && wlen == TIMEOUT) c_tmo++;
            in_wait = 0;
          end else begin
            wlen++;
          end
        end
        if (start_send_token) begin
          if (c_tok == 0) begin
            check("start_clears_success", txn_success, 0);
            check("start_clears_stalled", txn_stalled, 0);
            check("start_clears_fail_count", fail_count, 0);
          end
          c_tok++;
        end
        if (start_send_data) c_sd++;
        if (start_send_hand) c_sh++;
        if (start_recv_hand) begin c_rh++; in_wait = 1; wait_hand = 1; wlen = 1; wdone = 0; end
        if (start_recv_data) begin c_rd++; in_wait = 1; wait_hand = 0; wlen = 1; wdone = 0; end
        if (txn_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_txn_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("success", txn_success, e[63]);
            check("stalled", txn_stalled, e[62]);
            check("fail_count", fail_count, e[61:58]);
            check("token_pulses", c_tok, e[57:50]);
            check("send_data_pulses", c_sd, e[49:42]);
            check("recv_hand_pulses", c_rh, e[41:34]);
            check("recv_data_pulses", c_rd, e[33:26]);
            check("send_hand_pulses", c_sh, e[25:18]);
            check("timeouts", c_tmo, e[17:10]);
            last_s = e[63]; last_st = e[62]; last_fc = e[61:58]; have_last = 1;
          end
          c_tok = 0; c_sd = 0; c_rh = 0; c_rd = 0; c_sh = 0; c_tmo = 0; in_wait = 0;
        end else if (!busy && have_last) begin
          check("idle_hold_success", txn_success, last_s);
          check("idle_hold_stalled", txn_stalled, last_st);
          check("idle_hold_fail_count", fail_count, last_fc);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic fill_plan(input int k0, input int k1, input int k2, input int k3, input int rest);
    for (int i = 0; i < MAX_RETRY; i++) plan[i] = rest;
    plan[0] = k0; plan[1] = k1; plan[2] = k2; plan[3] = k3;
  endtask

  task automatic run_txn(input logic rw);
    int cyc;
    bit seen;
    plan_rw = rw;
    att = -1;
    exp_q.push_back(model());
    @(negedge clk);
    start = 1'b1;
    read_write = rw;
    @(negedge clk);
    cyc = 0;
    seen = 0;
    // Junk start/read_write while busy must be ignored.
    while (cyc < TXN_BUDGET) begin
      if (txn_done) begin
        seen = 1;
        break;
      end
      start = 1'($urandom_range(1, 0));
      read_write = 1'($urandom_range(1, 0));
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("txn_done_seen", seen, 1);
    if (!seen) begin
      do_reset();
      exp_q.delete();
    end
    repeat ($urandom_range(3, 1)) @(negedge clk);
  endtask

  task automatic random_plan(input logic rw);
    int r;
    bit doom;
    doom = ($urandom_range(5, 0) == 0);
    for (int i = 0; i < MAX_RETRY; i++) begin
      r = $urandom_range(99, 0);
      if (doom) begin
        plan[i] = (r < 60) ? K_BAD : (rw && r < 80) ? K_INV : K_SILENT;
      end else if (rw) begin
        plan[i] = (r < 30) ? K_GOOD : (r < 60) ? K_BAD : (r < 70) ? K_STALL :
                  (r < 80) ? K_INV : (r < 92) ? K_SILENT : K_LATE;
      end else begin
        plan[i] = (r < 30) ? K_GOOD : (r < 75) ? K_BAD : (r < 90) ? K_SILENT : K_LATE;
      end
    end
  endtask

  initial begin : driver
    int cyc;
    logic rw;
    for (int i = 0; i < MAX_RETRY; i++) plan[i] = K_GOOD;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fill_plan(K_GOOD, K_GOOD, K_GOOD, K_GOOD, K_GOOD);       run_txn(1'b1);
    fill_plan(K_BAD, K_BAD, K_BAD, K_GOOD, K_GOOD);          run_txn(1'b1);
    fill_plan(K_BAD, K_BAD, K_BAD, K_BAD, K_BAD);            run_txn(1'b0);
    fill_plan(K_SILENT, K_SILENT, K_SILENT, K_SILENT, K_SILENT); run_txn(1'b0);
    fill_plan(K_STALL, K_GOOD, K_GOOD, K_GOOD, K_GOOD);      run_txn(1'b1);
    fill_plan(K_INV, K_SILENT, K_LATE, K_GOOD, K_GOOD);      run_txn(1'b1);
    fill_plan(K_LATE, K_GOOD, K_GOOD, K_GOOD, K_GOOD);       run_txn(1'b0);
    fill_plan(K_SILENT, K_BAD, K_GOOD, K_GOOD, K_GOOD);      run_txn(1'b0);

    // Abort a write while its data phase is in flight.
    fill_plan(K_GOOD, K_GOOD, K_GOOD, K_GOOD, K_GOOD);
    plan_rw = 1'b1;
    att = -1;
    @(negedge clk);
    start = 1'b1;
    read_write = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!start_send_data && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_send_data", start_send_data, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_outputs_zero",
          {busy, txn_done, txn_success, txn_stalled, start_send_token, start_send_data,
           start_send_hand, start_recv_data, start_recv_hand, fail_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    fill_plan(K_GOOD, K_GOOD, K_GOOD, K_GOOD, K_GOOD);       run_txn(1'b1);

    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom_range(1, 0));
      random_plan(rw);
      run_txn(rw);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
